rx_iq_packer: RTL
=================

# rx_iq_packer

Downstream of the per-receiver DDC chains. Collects the 24-bit I/Q samples each receiver emits on its output strobe, and waits until every active receiver holds a fresh sample. It then snapshots the set and serialises it, MSB first, into the OpenHPSDR1 sample-group byte order: I2 I1 I0 Q2 Q1 Q0 per receiver, then two mic bytes. The byte stream feeds the EP6 frame builder over a valid/ready handshake.

## Interface
- NRX, 4: number of receiver inputs (1..8).
- clock  in  1  61.44 MHz system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_strobe  in  NRX  bit k: one-cycle pulse, receiver k sample valid.
- rx_i  in  24*NRX  receiver k I at bits [24k+23:24k], two's complement.
- rx_q  in  24*NRX  receiver k Q, same packing.
- mic  in  16  mic sample, sampled at snapshot.
- nrx_active  in  4  receivers in use. 0 is treated as 1; values above NRX are clamped to NRX.
- out_data  out  8  byte to frame builder.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts byte when out_valid & out_ready.
- out_last  out  1  high with the final (second mic) byte of a group.
- overrun  out  1  sticky: a receiver sample was overwritten before being sent.
- overrun_clr  in  1  clears overrun.

## Operation
- Per receiver k, a holding register of 48 bits plus a pending bit.
  - rx_strobe[k] loads the holding register and sets pending[k].
  - If pending[k] is already set at that strobe, the holding register is overwritten and overrun sets.
- States: IDLE and SEND.
- IDLE:
  - Let n = clamped nrx_active.
  - When pending[0..n-1] are all set, copy holding regs 0..n-1 and mic into the shadow buffer.
  - Latch n, clear pending[0..n-1], reset rx_idx and byte_idx to 0, and go to SEND.
  - pending bits of receivers at index ≥ n are never consulted. They still set on strobe; overwriting them also sets overrun.
- SEND:
  - out_valid = 1.
  - For rx_idx < n, out_data is shadow receiver rx_idx byte byte_idx, where bytes 0..5 = I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
  - For rx_idx = n, byte_idx 0..1 = mic[15:8], mic[7:0].
  - On each accepted byte, byte_idx increments. At 5 (or at 1 for mic), byte_idx wraps to 0 and rx_idx increments.
  - out_last is high while the mic byte 1 is presented.
  - Acceptance of the out_last byte returns the block to IDLE.
  - Group length is 6n+2 bytes.
- nrx_active changes during SEND are ignored until the next IDLE.
- Strobe on the snapshot cycle: the shadow takes the old holding value, the holding register takes the new one, and pending[k] stays set. No overrun is flagged.
- Strobes during SEND only affect holding registers and pending bits. The shadow is untouched.
- overrun_clr and a new overrun in the same cycle: overrun stays set.
- Reset values: all outputs 0, state IDLE, pending 0, counters 0. Reset mid-group abandons the group; out_valid drops the cycle after rst is sampled.

## Timing
- Snapshot happens on the clock edge where the all-pending condition is true in IDLE. out_valid rises on the next edge, and byte 0 is presented at that point.
- Outputs are registered or driven from state and counter registers only. There is no combinational path from out_ready to out_valid or out_data.
- When out_ready is held high, one byte is transferred per clock, so a group takes 6n+2 cycles.
- out_data, out_valid and out_last must hold stable while out_valid & !out_ready.
- After the last byte is accepted, out_valid is 0 for at least one cycle (IDLE) before the next group.
- Minimum strobe spacing at the 384 kHz rate is 160 clocks. This covers 26 bytes for NRX=4 at full throughput.

## Test plan
- Basic group:
  - Stimulus: NRX=4, nrx_active=2, out_ready=1. Strobe both receivers with I0=0x123456, Q0=0x789ABC, I1=0xFEDCBA, Q1=0x000001, mic=0xA55A.
  - Required: out_valid rises one cycle later. 14 bytes follow: 12 34 56 78 9A BC FE DC BA 00 00 01 A5 5A, with out_last on 5A. out_valid is then 0.
- Backpressure:
  - Stimulus: the same group, with out_ready toggling 1,0,0,1 repeatedly.
  - Required: identical byte sequence, data held stable during stalls, no duplicated or dropped bytes.
- Staggered strobes:
  - Stimulus: receiver 1 strobes 7 cycles after receiver 0.
  - Required: no out_valid until the cycle after receiver 1's strobe.
- Overrun:
  - Stimulus: hold out_ready=0 in SEND. Strobe receiver 0 twice, first with 0x111111, then 0x222222.
  - Required: overrun=1. The next group carries 0x222222. overrun_clr pulse makes overrun 0.
- Snapshot collision:
  - Stimulus: a receiver 0 strobe lands exactly on the snapshot cycle.
  - Required: the current group carries the old sample, the next group carries the new one, overrun stays 0.
- Reset and clamp:
  - Stimulus: assert rst at byte 5 of a group, then release. Next, set nrx_active=0, and separately nrx_active=9 with NRX=4.
  - Required: after rst, out_valid=0, overrun=0, and the next group starts from byte 0. nrx_active=0 gives 8-byte groups; nrx_active=9 gives 26-byte groups.

Source files
------------

// File: rtl/rx_iq_packer.sv
// rx_iq_packer: collects 24-bit I/Q samples from NRX receivers, waits until
// every active receiver holds a fresh sample, snapshots the set plus the mic
// sample, and serialises it MSB first as I2 I1 I0 Q2 Q1 Q0 per receiver
// followed by two mic bytes, over a valid/ready byte stream.
module rx_iq_packer #(
  parameter int NRX = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NRX-1:0]    rx_strobe,
  input  logic [24*NRX-1:0] rx_i,
  input  logic [24*NRX-1:0] rx_q,
  input  logic [15:0]       mic,
  input  logic [3:0]        nrx_active,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun,
  input  logic              overrun_clr
);

  // Wide enough to count receivers 0..NRX, where NRX selects the mic slot.
  localparam int CW = $clog2(NRX + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t         state;
  logic [23:0]    hold_i   [NRX];
  logic [23:0]    hold_q   [NRX];
  logic [23:0]    shadow_i [NRX];
  logic [23:0]    shadow_q [NRX];
  logic [15:0]    shadow_mic;
  logic [NRX-1:0] pending;
  logic [NRX-1:0] clear_mask;
  logic [CW-1:0]  n_eff;
  logic [CW-1:0]  n_lat;
  logic [CW-1:0]  rx_idx;
  logic [2:0]     byte_idx;
  logic           all_pending;
  logic           snap;
  logic [47:0]    word;

  // Clamp the requested receiver count into 1..NRX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    n_eff = CW'(NRX);
    if (nrx_active == 4'd0)
      n_eff = CW'(1);
    else if (nrx_active <= 4'(NRX))
      n_eff = nrx_active[CW-1:0];
  end

  // Decide whether all active receivers are pending; only those get cleared on snapshot.
  always_comb begin
    all_pending = 1'b1;
    clear_mask  = '0;
    for (int k = 0; k < NRX; k++) begin
      if (CW'(k) < n_eff) begin
        if (!pending[k])
          all_pending = 1'b0;
        clear_mask[k] = 1'b1;
      end
    end
    if (!(state == IDLE && all_pending))
      clear_mask = '0;
  end

  assign snap = (state == IDLE) && all_pending;

  // Holding registers load on their receiver's strobe.
  always_ff @(posedge clock) begin
    // NOTE: sample storage is not reset; pending bits and the FSM decide when it is read.
    for (int k = 0; k < NRX; k++) begin
      if (rx_strobe[k]) begin
        hold_i[k] <= rx_i[24*k +: 24];
        hold_q[k] <= rx_q[24*k +: 24];
      end
    end
  end

  // Pending bits and sticky overrun; a strobe on the snapshot edge re-arms pending without overrun.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clear_mask) | rx_strobe;
      if (|(rx_strobe & pending & ~clear_mask))
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  // Shadow buffer captures the holding registers and mic at the snapshot edge.
  always_ff @(posedge clock) begin
    if (snap) begin
      for (int k = 0; k < NRX; k++) begin
        shadow_i[k] <= hold_i[k];
        shadow_q[k] <= hold_q[k];
      end
      shadow_mic <= mic;
    end
  end

  // Group sequencer: walk receivers then the mic slot, one byte per accepted transfer.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      n_lat    <= '0;
      rx_idx   <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snap) begin
            n_lat    <= n_eff;
            rx_idx   <= '0;
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (rx_idx == n_lat) begin
              if (byte_idx == 3'd1) begin
                state    <= IDLE;
                rx_idx   <= '0;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 3'd1;
              end
            end else if (byte_idx == 3'd5) begin
              byte_idx <= '0;
              rx_idx   <= rx_idx + CW'(1);
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == SEND);

  // Output byte decoded from the shadow buffer and the registered counters only.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    word     = '0;
    if (state == SEND) begin
      if (rx_idx == n_lat) begin
        out_data = (byte_idx == 3'd1) ? shadow_mic[7:0] : shadow_mic[15:8];
        out_last = (byte_idx == 3'd1);
      end else begin
        for (int k = 0; k < NRX; k++) begin
          if (rx_idx == CW'(k))
            word = {shadow_i[k], shadow_q[k]};
        end
        case (byte_idx)
          3'd0:    out_data = word[47:40];
          3'd1:    out_data = word[39:32];
          3'd2:    out_data = word[31:24];
          3'd3:    out_data = word[23:16];
          3'd4:    out_data = word[15:8];
          default: out_data = word[7:0];
        endcase
      end
    end
  end

endmodule
